regfile_issue_ctrl: RTL and testbench

//  Issue controller for the 32x32 operand register file (RV32I). Sits between decode and the

---
 rtl/regfile_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_regfile_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_issue_ctrl.sv
// Issue controller for the RV32I 32x32 register file: scoreboard-based RAW/WAW
// stalls, same-cycle writeback bypass, and rs1 read-port sharing with a debug reader.
module regfile_issue_ctrl #(
  parameter int unsigned DBG_MAX_WAIT = 4,
  parameter bit          BYPASS_EN    = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_use,
  input  logic        dec_rs2_use,
  input  logic [4:0]  dec_rd,
  input  logic        dec_rd_use,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic        rf_rs1_ren,
  output logic        rf_rs2_ren,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  output logic [4:0]  rf_rd,
  output logic        rf_rd_wen,
  output logic [31:0] rf_rd_data,
  output logic        op_valid,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [4:0]  op_rd,
  output logic        op_rd_use,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [31:0] busy_vec
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(DBG_MAX_WAIT + 1);

  typedef enum logic [1:0] {S_RUN, S_DBG, S_FLUSH} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_RF, SEL_BYP} opsel_t;

  state_t         state;
  opsel_t         op1_sel, op2_sel, sel1_nxt, sel2_nxt;
  logic [CW-1:0]  dbg_cnt;
  logic [DW-1:0]  wb_data_q;
  logic [DW-1:0]  busy_nxt;
  logic           dbg_zero_q;
  logic           byp1, byp2, haz1, haz2, waw, dbg_force, fire;

  // Write port is a straight copy of writeback; x0 is never written.
  assign rf_rd      = wb_rd;
  assign rf_rd_wen  = wb_valid && (wb_rd != AW'(0));
  assign rf_rd_data = wb_data;

  // Hazard detection, issue handshake and rs1 port arbitration.
  always_comb begin
    byp1      = BYPASS_EN && wb_valid && (wb_rd == dec_rs1) && dec_rs1_use && (dec_rs1 != AW'(0));
    byp2      = BYPASS_EN && wb_valid && (wb_rd == dec_rs2) && dec_rs2_use && (dec_rs2 != AW'(0));
    haz1      = dec_rs1_use && (dec_rs1 != AW'(0)) && busy_vec[dec_rs1] && !byp1;
    haz2      = dec_rs2_use && (dec_rs2 != AW'(0)) && busy_vec[dec_rs2] && !byp2;
    waw       = dec_rd_use && (dec_rd != AW'(0)) && busy_vec[dec_rd] &&
                !(wb_valid && (wb_rd == dec_rd));
    dbg_force = dbg_req && (dbg_cnt == CW'(DBG_MAX_WAIT));
    dec_ready = RSTN && (state != S_FLUSH) && !flush && !haz1 && !haz2 && !waw && !dbg_force;
    fire      = dec_valid && dec_ready;
    dbg_gnt   = RSTN && dbg_req && !flush && (!(fire && dec_rs1_use) || dbg_force);

    rf_rs1     = dbg_gnt ? dbg_addr : dec_rs1;
    rf_rs1_ren = dbg_gnt || (fire && dec_rs1_use);
    rf_rs2     = dec_rs2;
    rf_rs2_ren = fire && dec_rs2_use;

    sel1_nxt = SEL_ZERO;
    if (fire && dec_rs1_use && (dec_rs1 != AW'(0))) sel1_nxt = byp1 ? SEL_BYP : SEL_RF;
    sel2_nxt = SEL_ZERO;
    if (fire && dec_rs2_use && (dec_rs2 != AW'(0))) sel2_nxt = byp2 ? SEL_BYP : SEL_RF;
  end

  // Scoreboard: writeback clears, issue sets (set wins), flush wipes everything.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (fire && dec_rd_use) busy_nxt[dec_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Operands and debug data come from the RF one cycle after the read enable.
  always_comb begin
    op1 = '0;
    op2 = '0;
    case (op1_sel)
      SEL_RF:  op1 = rf_rs1_data;
      SEL_BYP: op1 = wb_data_q;
      default: op1 = '0;
    endcase
    case (op2_sel)
      SEL_RF:  op2 = rf_rs2_data;
      SEL_BYP: op2 = wb_data_q;
      default: op2 = '0;
    endcase
    dbg_rdata = (dbg_rvalid && !dbg_zero_q) ? rf_rs1_data : '0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_RUN;
      busy_vec   <= '0;
      dbg_cnt    <= '0;
      op_valid   <= 1'b0;
      op1_sel    <= SEL_ZERO;
      op2_sel    <= SEL_ZERO;
      wb_data_q  <= '0;
      op_rd      <= '0;
      op_rd_use  <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_zero_q <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (flush)        state <= S_FLUSH;
          else if (dbg_gnt) state <= S_DBG;
        end
        S_DBG: begin
          if (flush)         state <= S_FLUSH;
          else if (!dbg_gnt) state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase

      busy_vec <= busy_nxt;

      if (dbg_gnt)                                     dbg_cnt <= '0;
      else if (dbg_req && (dbg_cnt != CW'(DBG_MAX_WAIT))) dbg_cnt <= dbg_cnt + CW'(1);

      op_valid <= fire;
      op1_sel  <= sel1_nxt;
      op2_sel  <= sel2_nxt;
      if (fire) begin
        wb_data_q <= wb_data;
        op_rd     <= dec_rd;
        op_rd_use <= dec_rd_use;
      end

      dbg_rvalid <= dbg_gnt;
      dbg_zero_q <= (dbg_addr == AW'(0));
    end
  end

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Directed bench for regfile_issue_ctrl: a cycle table with hand-computed outputs
// against a small register-file model, plus reset and no-bypass sequences.
module tb_regfile_issue_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        flush, dec_valid, dec_valid0, dec_rs1_use, dec_rs2_use, dec_rd_use;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, dbg_addr;
  logic        wb_valid, dbg_req, dbg_req0;
  logic [31:0] wb_data;
  logic [31:0] rf_rs1_data, rf_rs2_data, rf_rs1_data0, rf_rs2_data0;

  logic        dec_ready, rf_rs1_ren, rf_rs2_ren, rf_rd_wen, op_valid, op_rd_use;
  logic        dbg_gnt, dbg_rvalid;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd, op_rd;
  logic [31:0] rf_rd_data, op1, op2, dbg_rdata, busy_vec;

  logic        dec_ready0, rf_rs1_ren0, rf_rs2_ren0, rf_rd_wen0, op_valid0, op_rd_use0;
  logic        dbg_gnt0, dbg_rvalid0;
  logic [4:0]  rf_rs10, rf_rs20, rf_rd0, op_rd0;
  logic [31:0] rf_rd_data0, op10, op20, dbg_rdata0, busy_vec0;

  logic [31:0] mem [32];
  logic        mem_init;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic dv; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic [4:0] rd; logic rdu;
    logic wv; logic [4:0] wrd; logic [31:0] wd; logic dq; logic [4:0] da; logic fl;
  } in_t;
  typedef struct {
    logic rdy; logic gnt; logic wen; logic ov; logic [31:0] op1; logic [31:0] op2;
    logic [4:0] ord; logic ordu; logic [31:0] busy; logic rv; logic [31:0] rdata;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t tbl[$];

  always #5 CLK = ~CLK;

  regfile_issue_ctrl #(.DBG_MAX_WAIT(4), .BYPASS_EN(1'b1)) dut (
    .CLK(CLK), .RSTN(RSTN), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use),
    .dec_rd(dec_rd), .dec_rd_use(dec_rd_use), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_ren(rf_rs1_ren), .rf_rs2_ren(rf_rs2_ren),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .rf_rd(rf_rd), .rf_rd_wen(rf_rd_wen),
    .rf_rd_data(rf_rd_data), .op_valid(op_valid), .op1(op1), .op2(op2), .op_rd(op_rd),
    .op_rd_use(op_rd_use), .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .busy_vec(busy_vec)
  );

  // No-bypass variant: shares decode fields and writeback, own dec_valid and RF read data.
  regfile_issue_ctrl #(.DBG_MAX_WAIT(4), .BYPASS_EN(1'b0)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .flush(flush), .dec_valid(dec_valid0), .dec_ready(dec_ready0),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs1_use(dec_rs1_use), .dec_rs2_use(dec_rs2_use),
    .dec_rd(dec_rd), .dec_rd_use(dec_rd_use), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1(rf_rs10), .rf_rs2(rf_rs20), .rf_rs1_ren(rf_rs1_ren0), .rf_rs2_ren(rf_rs2_ren0),
    .rf_rs1_data(rf_rs1_data0), .rf_rs2_data(rf_rs2_data0), .rf_rd(rf_rd0), .rf_rd_wen(rf_rd_wen0),
    .rf_rd_data(rf_rd_data0), .op_valid(op_valid0), .op1(op10), .op2(op20), .op_rd(op_rd0),
    .op_rd_use(op_rd_use0), .dbg_req(dbg_req0), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt0),
    .dbg_rvalid(dbg_rvalid0), .dbg_rdata(dbg_rdata0), .busy_vec(busy_vec0)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'hDEAD_0000;
      3:       return 32'h55;
      5:       return 32'h11;
      6:       return 32'h22;
      default: return 32'(32'h100 + i);
    endcase
  endfunction

  // Register-file model: synchronous write, registered read (old data on same-edge write).
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (rf_rd_wen) begin
      mem[rf_rd] <= rf_rd_data;
    end
    if (rf_rs1_ren)  rf_rs1_data  <= mem[rf_rs1];
    if (rf_rs2_ren)  rf_rs2_data  <= mem[rf_rs2];
    if (rf_rs1_ren0) rf_rs1_data0 <= mem[rf_rs10];
    if (rf_rs2_ren0) rf_rs2_data0 <= mem[rf_rs20];
  end

  function automatic in_t mi(input int dv, input int r1, input int r2, input int u1, input int u2,
                             input int rd, input int rdu, input int wv, input int wrd,
                             input logic [31:0] wd, input int dq, input int da, input int fl);
    in_t v;
    v.dv = 1'(dv); v.rs1 = 5'(r1); v.rs2 = 5'(r2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.rd = 5'(rd); v.rdu = 1'(rdu); v.wv = 1'(wv); v.wrd = 5'(wrd); v.wd = wd;
    v.dq = 1'(dq); v.da = 5'(da); v.fl = 1'(fl);
    return v;
  endfunction

  function automatic exp_t me(input int rdy, input int gnt, input int wen, input int ov,
                              input logic [31:0] o1, input logic [31:0] o2, input int ord,
                              input int ordu, input logic [31:0] busy, input int rv,
                              input logic [31:0] rdata);
    exp_t e;
    e.rdy = 1'(rdy); e.gnt = 1'(gnt); e.wen = 1'(wen); e.ov = 1'(ov); e.op1 = o1; e.op2 = o2;
    e.ord = 5'(ord); e.ordu = 1'(ordu); e.busy = busy; e.rv = 1'(rv); e.rdata = rdata;
    return e;
  endfunction

  function automatic void add(input in_t i, input exp_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic apply(input in_t v);
    dec_valid = v.dv; dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rs1_use = v.u1; dec_rs2_use = v.u2;
    dec_rd = v.rd; dec_rd_use = v.rdu; wb_valid = v.wv; wb_rd = v.wrd; wb_data = v.wd;
    dbg_req = v.dq; dbg_addr = v.da; flush = v.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int n, input exp_t e);
    vectors++;
    chk($sformatf("v%0d dec_ready", n), 32'(dec_ready), 32'(e.rdy));
    chk($sformatf("v%0d dbg_gnt", n), 32'(dbg_gnt), 32'(e.gnt));
    chk($sformatf("v%0d rf_rd_wen", n), 32'(rf_rd_wen), 32'(e.wen));
    chk($sformatf("v%0d op_valid", n), 32'(op_valid), 32'(e.ov));
    chk($sformatf("v%0d busy_vec", n), busy_vec, e.busy);
    chk($sformatf("v%0d dbg_rvalid", n), 32'(dbg_rvalid), 32'(e.rv));
    if (e.ov) begin
      chk($sformatf("v%0d op1", n), op1, e.op1);
      chk($sformatf("v%0d op2", n), op2, e.op2);
      chk($sformatf("v%0d op_rd", n), 32'(op_rd), 32'(e.ord));
      chk($sformatf("v%0d op_rd_use", n), 32'(op_rd_use), 32'(e.ordu));
    end
    if (e.rv) chk($sformatf("v%0d dbg_rdata", n), dbg_rdata, e.rdata);
  endtask

  task automatic check_reset(input string tag);
    vectors++;
    chk({tag, " dec_ready"}, 32'(dec_ready), 32'h0);
    chk({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'h0);
    chk({tag, " op_valid"}, 32'(op_valid), 32'h0);
    chk({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'h0);
    chk({tag, " dbg_rdata"}, dbg_rdata, 32'h0);
    chk({tag, " op1"}, op1, 32'h0);
    chk({tag, " op2"}, op2, 32'h0);
    chk({tag, " op_rd"}, 32'(op_rd), 32'h0);
    chk({tag, " op_rd_use"}, 32'(op_rd_use), 32'h0);
    chk({tag, " busy_vec"}, busy_vec, 32'h0);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    in_t idle;
    idle = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);

    // Row table: decode/writeback/debug inputs for one cycle and the outputs expected in it.
    add(mi(1, 5, 6, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(idle, me(1, 0, 0, 1, 32'h11, 32'h22, 0, 0, 32'h0, 0, 0));
    add(mi(1, 1, 2, 1, 0, 7, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 7, 0, 1, 0, 8, 0, 0, 0, 32'h0, 0, 0, 0), me(0, 0, 0, 1, 32'h101, 0, 7, 1, 32'h80, 0, 0));
    add(mi(1, 7, 0, 1, 0, 8, 0, 0, 0, 32'h0, 0, 0, 0), me(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 0, 0));
    add(mi(1, 7, 0, 1, 0, 8, 0, 1, 7, 32'hABCD, 0, 0, 0), me(1, 0, 1, 0, 0, 0, 0, 0, 32'h80, 0, 0));
    add(idle, me(1, 0, 0, 1, 32'hABCD, 0, 8, 0, 32'h0, 0, 0));
    add(mi(1, 0, 0, 0, 0, 9, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 0, 0, 0, 0, 9, 1, 1, 9, 32'h99, 0, 0, 0), me(1, 0, 1, 1, 0, 0, 9, 1, 32'h200, 0, 0));
    add(mi(1, 0, 0, 0, 0, 0, 1, 1, 9, 32'h999, 0, 0, 0), me(1, 0, 1, 1, 0, 0, 9, 1, 32'h200, 0, 0));
    add(idle, me(1, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    add(mi(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 3, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    for (int k = 0; k < 3; k++)
      add(mi(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 3, 0), me(1, 0, 0, 1, 32'h101, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 3, 0), me(0, 1, 0, 1, 32'h101, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h55));
    add(mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0), me(1, 1, 0, 1, 32'h101, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 0, 6, 0, 1, 0, 0, 0, 0, 32'h0, 1, 5, 0), me(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0));
    add(idle, me(1, 0, 0, 1, 0, 32'h22, 0, 0, 32'h0, 1, 32'h11));
    add(mi(1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 0, 0, 0, 0, 2, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 1, 0, 0, 1, 1, 32'h2, 0, 0));
    add(mi(1, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 1, 0, 0, 2, 1, 32'h6, 0, 0));
    add(mi(1, 0, 0, 0, 0, 4, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 1, 0, 0, 3, 1, 32'hE, 0, 0));
    add(mi(1, 0, 0, 0, 0, 5, 1, 1, 10, 32'h1010, 1, 10, 1), me(0, 0, 1, 1, 0, 0, 4, 1, 32'h1E, 0, 0));
    add(mi(1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0, 1, 10, 0), me(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(mi(1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h1010));
    add(idle, me(1, 0, 0, 1, 0, 0, 5, 1, 32'h20, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5555, 0, 0, 0), me(1, 0, 1, 0, 0, 0, 0, 0, 32'h20, 0, 0));
    add(mi(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h7777, 0, 0, 0), me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    add(idle, me(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));

    // Reset with decode and a debug request already asserted.
    RSTN = 1'b0;
    mem_init = 1'b1;
    dec_valid0 = 1'b0;
    dbg_req0 = 1'b0;
    apply(mi(1, 5, 6, 1, 1, 7, 1, 1, 3, 32'h1, 1, 3, 0));
    repeat (3) @(posedge CLK);
    #1;
    check_reset("reset");
    mem_init = 1'b0;
    apply(idle);
    RSTN = 1'b1;

    foreach (tbl[n]) begin
      cyc();
      apply(tbl[n].i);
      #4;
      check_vec(n, tbl[n].e);
    end

    // Same RAW hazard on the no-bypass instance: issue waits for the writeback to retire.
    cyc(); apply(idle); dec_valid0 = 1'b1; dec_rd = 5'd12; dec_rd_use = 1'b1;
    #4; vectors++; chk("nobyp set rdy", 32'(dec_ready0), 32'h1);
    cyc(); dec_rs1 = 5'd12; dec_rs1_use = 1'b1; dec_rd = 5'd0; dec_rd_use = 1'b0;
    #4; vectors++; chk("nobyp stall rdy", 32'(dec_ready0), 32'h0);
    chk("nobyp busy", busy_vec0, 32'h1000);
    cyc(); wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hC0DE;
    #4; vectors++; chk("nobyp wb rdy", 32'(dec_ready0), 32'h0);
    cyc(); wb_valid = 1'b0;
    #4; vectors++; chk("nobyp fire rdy", 32'(dec_ready0), 32'h1);
    cyc(); dec_valid0 = 1'b0;
    #4; vectors++; chk("nobyp op_valid", 32'(op_valid0), 32'h1);
    chk("nobyp op1", op10, 32'hC0DE);
    chk("nobyp busy clr", busy_vec0, 32'h0);

    // Reset lands while an issue and a debug read are both in flight.
    cyc(); apply(mi(1, 5, 6, 0, 1, 13, 1, 0, 0, 32'h0, 1, 3, 0));
    #4; vectors++; chk("midrst pre rdy", 32'(dec_ready), 32'h1);
    chk("midrst pre gnt", 32'(dbg_gnt), 32'h1);
    @(posedge CLK); #1;
    RSTN = 1'b0;
    #2;
    check_reset("midrst");
    apply(idle);
    @(posedge CLK); #1;
    RSTN = 1'b1;
    cyc(); #4;
    vectors++;
    chk("postrst op_valid", 32'(op_valid), 32'h0);
    chk("postrst dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    chk("postrst rdy", 32'(dec_ready), 32'h1);
    chk("postrst busy", busy_vec, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
